// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory responder for a pipeline MEM stage.
// It accepts one request at a time, waits WAIT_STATES cycles, then holds the
// response until the requester takes it.
// Optional access checking is enabled with `define DMEM_RESPONDER_ERR_CHECK_EN.
// Without it, rsp_err is tied to 0, addr[1:0] is ignored and word indices wrap.
//
// state  | meaning
// -------+---------------------------------------------------------
// S_IDLE | ready for a request (req_ready=1)
// S_WAIT | wait-state down-counter running toward terminal count 1
// S_RESP | response presented (rsp_valid=1) until rsp_ready
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         wait_cnt;
    logic               write_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;
    logic [31:0]        rdata_q;
    logic [31:0]        mem [DEPTH_WORDS];

    logic               accept;
    logic               enter_resp;
    logic               commit;
    logic               cur_write;
    logic [31:0]        cur_addr;
    logic [31:0]        cur_wdata;
    logic [3:0]         cur_be;
    logic [IDX_W-1:0]   cur_idx;
    logic               cur_err;

    // In IDLE the transaction is still on the request bus; afterwards it lives
    // in the request registers. This lets the zero-wait and error paths commit
    // and read on the acceptance edge itself.
    assign cur_write = (state == S_IDLE) ? req_write : write_q;
    assign cur_addr  = (state == S_IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state == S_IDLE) ? req_wdata : wdata_q;
    assign cur_be    = (state == S_IDLE) ? req_be    : be_q;
    assign cur_idx   = cur_addr[IDX_W+1:2];

    assign accept     = req_valid && (state == S_IDLE);
    assign enter_resp = (state != S_RESP) && (state_nxt == S_RESP);
    assign commit     = enter_resp && cur_write && !cur_err;

`ifdef DMEM_RESPONDER_ERR_CHECK_EN
    logic addr_err;
    logic err_q;

    assign addr_err = (cur_addr[1:0] != 2'b00) ||
                      ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign cur_err  = (state == S_IDLE) ? addr_err : err_q;
    assign rsp_err  = (state == S_RESP) && err_q;

    // Latch the error verdict with the request so it stays stable through RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= addr_err;
        end
    end
`else
    logic unused_addr_bits;

    // Byte offset and bits above the word index are deliberately dropped.
    assign unused_addr_bits = ^{cur_addr[31:IDX_W+2], cur_addr[1:0]};
    assign cur_err          = 1'b0;
    assign rsp_err          = 1'b0;
`endif

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_rdata = (state == S_RESP) ? rdata_q : 32'h0;

    // Next-state logic; erroring accesses skip the wait phase.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (cur_err || (WAIT_STATES == 0)) state_nxt = S_RESP;
                    else                               state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd1) state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, wait counter, request capture and response data registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            write_q  <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            be_q     <= 4'h0;
            rdata_q  <= 32'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if ((state == S_IDLE) && (state_nxt == S_WAIT)) begin
                wait_cnt <= 4'(WAIT_STATES);
            end else if (state == S_WAIT) begin
                wait_cnt <= (wait_cnt == 4'd1) ? 4'd0 : wait_cnt - 4'd1;
            end
            // Load data is captured once on entry so it cannot move under backpressure.
            if (enter_resp) begin
                rdata_q <= (cur_write || cur_err) ? 32'h0 : mem[cur_idx];
            end
        end
    end

    // Storage is never reset; stores land on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
        end
    end

endmodule
